rv_hazard_fwd: RTL
==================

# rv_hazard_fwd

Parametrised operand-forwarding and load-use hazard unit for the RV32 core pipeline. It sits between the register file read port and the ALU stage. It selects each ALU source operand from the youngest in-flight producer: ALU2 result, write-stage result, or a configurable-depth history of retired write-backs. It also detects load-use hazards, raises a stall request, and keeps a saturating stall counter for performance monitoring.

## Interface
Parameters:
- XLEN, 32, datapath width
- REG_AW, 5, register address width; address 0 is hard-zero and never forwards
- WB_DEPTH, 2, retired write-back history entries (legal range 1..8)
- ALU2_ISOLATED, 0, when 1, ALU2 never forwards and load-use stall is disabled
- LOAD_STALL_EN, 1, enables load-use stall detection
- CNT_W, 16, stall counter width

Ports:
- i_clk  in  1  core clock
- i_reset  in  1  synchronous, active-high reset
- i_alu_valid  in  1  ALU stage holds a valid instruction
- i_alu_rs1 / i_alu_rs2  in  REG_AW  source register addresses
- i_alu_rs1_used / i_alu_rs2_used  in  1  instruction actually reads rs1/rs2
- i_alu2_rd  in  REG_AW  ALU2 destination
- i_alu2_reg_write  in  1  ALU2 will write rd
- i_alu2_is_load  in  1  ALU2 instruction is a load (data not yet valid)
- i_alu2_data  in  XLEN  ALU2 result
- i_write_rd  in  REG_AW  write-stage destination
- i_write_reg_write  in  1  write-stage writes rd this cycle
- i_wr_data  in  XLEN  write-stage data
- i_reg_data1 / i_reg_data2  in  XLEN  register file read data
- o_data1 / o_data2  out  XLEN  forwarded operands
- o_src1 / o_src2  out  2  selected source: 0 regfile, 1 ALU2, 2 write, 3 history
- o_stall  out  1  load-use stall request to the front end
- o_stall_cnt  out  CNT_W  saturating count of stall cycles

## Operation
- History: a shift register of WB_DEPTH entries {valid, rd, data}. On every non-reset clock, entry 0 takes {i_write_reg_write & (i_write_rd!=0), i_write_rd, i_wr_data}, and entry k takes entry k-1. Shifting is unconditional, including during a stall.
- Match for operand n:
  - ALU2 match: i_alu2_reg_write & rs!=0 & rs==i_alu2_rd & !ALU2_ISOLATED & !i_alu2_is_load.
  - Write match: i_write_reg_write & rs!=0 & rs==i_write_rd.
  - History k match: valid_k & rs==rd_k.
- Priority: ALU2 > write > history 0 > history 1 > … > regfile. The youngest producer always wins, including duplicate rd values in the history.
- o_data mux is one-hot AND-OR; o_src reports the winning class.
- Load-use stall: o_stall = LOAD_STALL_EN & !ALU2_ISOLATED & !i_reset & i_alu_valid & i_alu2_reg_write & i_alu2_is_load & i_alu2_rd!=0 & ((rs1_used & rs1==i_alu2_rd) | (rs2_used & rs2==i_alu2_rd)).
- An unused operand (rsN_used=0) never causes a stall; its operand is still muxed normally.
- Stall counter: increments by 1 on each clock where o_stall=1. It saturates at all-ones and never wraps.

## Timing
- o_data1/2, o_src1/2 and o_stall are combinational from inputs and history state; the operand path has zero latency.
- History and counter update on posedge i_clk. A write-stage value is visible through history 0 exactly 1 cycle after it is presented, and through history k after k+1 cycles. It drops out after WB_DEPTH+1 cycles.
- Reset (synchronous, high):
  - All history valids clear and o_stall_cnt=0 at the next edge.
  - While i_reset=1, o_stall=0 and history does not capture.
  - ALU2 and write forwarding stay active combinationally.
- After reset release, the first capture happens at the first edge with i_reset=0.
- Reset and a counter increment in the same cycle: reset wins.
- Reset mid-stall: o_stall drops in the same cycle.
- A stall is held as long as the hazard condition persists. The unit does not freeze ALU2; the pipeline is responsible for advancing the load.

## Test plan
- Write x5=0xAAAA_0001 at write stage; ALU reads rs1=5 in the same cycle -> o_data1=0xAAAA_0001, o_src1=2. Next cycle, with the regfile still stale -> o_src1=3 and the same data.
- ALU2 rd=7=0x11, write rd=7=0x22, history holds x7=0x33; rs2=7 -> o_data2=0x11, o_src2=1. Drop ALU2 -> 0x22. Drop write -> 0x33.
- rs1=0 with every producer writing x0=0xFFFF_FFFF -> o_data1=i_reg_data1, o_src1=0, no stall.
- Load in ALU2 rd=9, consumer rs2=9, used, valid -> o_stall=1 and o_stall_cnt +1 per cycle. Set rs2_used=0 -> o_stall=0. ALU2_ISOLATED=1 build -> never stalls.
- WB_DEPTH=2: write x3=0x5 once, then idle -> forwarded from history for 2 cycles, regfile on the 3rd. Assert i_reset during cycle 1 -> history empty, o_src=0, o_stall_cnt=0.
- CNT_W=4: hold the stall 20 cycles -> o_stall_cnt stops at 15.

Source files
------------

// File: rtl/rv_hazard_fwd.sv
// Operand forwarding and load-use hazard unit for the RV32 pipeline.
// Picks each ALU operand from the youngest in-flight producer.
module rv_hazard_fwd #(
  parameter int XLEN          = 32,
  parameter int REG_AW        = 5,
  parameter int WB_DEPTH      = 2,
  parameter int ALU2_ISOLATED = 0,
  parameter int LOAD_STALL_EN = 1,
  parameter int CNT_W         = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_alu_valid,
  input  logic [REG_AW-1:0] i_alu_rs1,
  input  logic [REG_AW-1:0] i_alu_rs2,
  input  logic              i_alu_rs1_used,
  input  logic              i_alu_rs2_used,
  input  logic [REG_AW-1:0] i_alu2_rd,
  input  logic              i_alu2_reg_write,
  input  logic              i_alu2_is_load,
  input  logic [XLEN-1:0]   i_alu2_data,
  input  logic [REG_AW-1:0] i_write_rd,
  input  logic              i_write_reg_write,
  input  logic [XLEN-1:0]   i_wr_data,
  input  logic [XLEN-1:0]   i_reg_data1,
  input  logic [XLEN-1:0]   i_reg_data2,
  output logic [XLEN-1:0]   o_data1,
  output logic [XLEN-1:0]   o_data2,
  output logic [1:0]        o_src1,
  output logic [1:0]        o_src2,
  output logic              o_stall,
  output logic [CNT_W-1:0]  o_stall_cnt
);

  localparam bit FWD_A2   = (ALU2_ISOLATED == 0);
  localparam bit STALL_EN = (LOAD_STALL_EN != 0) && FWD_A2;

  logic [WB_DEPTH-1:0]             hv_q, hv_d;
  logic [WB_DEPTH-1:0][REG_AW-1:0] hrd_q, hrd_d;
  logic [WB_DEPTH-1:0][XLEN-1:0]   hdat_q, hdat_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic                            stall;

  // History shifts every cycle, stall or not; x0 writes never become valid.
  always_comb begin
    hv_d      = hv_q;
    hrd_d     = hrd_q;
    hdat_d    = hdat_q;
    hv_d[0]   = i_write_reg_write && (i_write_rd != '0);
    hrd_d[0]  = i_write_rd;
    hdat_d[0] = i_wr_data;
    for (int k = 1; k < WB_DEPTH; k++) begin
      hv_d[k]   = hv_q[k-1];
      hrd_d[k]  = hrd_q[k-1];
      hdat_d[k] = hdat_q[k-1];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      hv_q  <= '0;
      cnt_q <= '0;
    end else begin
      hv_q  <= hv_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      hrd_q  <= hrd_d;
      hdat_q <= hdat_d;
    end
  end

  logic [1:0][REG_AW-1:0] rs;
  logic [1:0][XLEN-1:0]   rf;
  logic [1:0][XLEN-1:0]   od;
  logic [1:0][1:0]        osrc;

  assign rs = {i_alu_rs2, i_alu_rs1};
  assign rf = {i_reg_data2, i_reg_data1};

  for (genvar n = 0; n < 2; n++) begin : g_op
    logic                a2_hit;
    logic                wr_hit;
    logic                wr_sel;
    logic                rf_sel;
    logic                taken;
    logic                h_any;
    logic [WB_DEPTH-1:0] h_sel;
    logic [XLEN-1:0]     od_n;

    always_comb begin
      a2_hit = FWD_A2 && i_alu2_reg_write && !i_alu2_is_load &&
               (rs[n] != '0) && (rs[n] == i_alu2_rd);
      wr_hit = i_write_reg_write && (rs[n] != '0) &&
               (rs[n] == i_write_rd);
      wr_sel = wr_hit && !a2_hit;
      taken  = a2_hit || wr_hit;
      h_sel  = '0;
      for (int k = 0; k < WB_DEPTH; k++) begin
        if (hv_q[k] && (rs[n] == hrd_q[k])) begin
          h_sel[k] = !taken;
          taken    = 1'b1;
        end
      end
      rf_sel = !taken;
      h_any  = |h_sel;
    end

    // Selects are one-hot, so the operand is a plain AND-OR.
    always_comb begin
      od_n = ({XLEN{a2_hit}} & i_alu2_data) |
             ({XLEN{wr_sel}} & i_wr_data) |
             ({XLEN{rf_sel}} & rf[n]);
      for (int k = 0; k < WB_DEPTH; k++) begin
        od_n = od_n | ({XLEN{h_sel[k]}} & hdat_q[k]);
      end
    end

    assign od[n]   = od_n;
    assign osrc[n] = {wr_sel | h_any, a2_hit | h_any};
  end

  always_comb begin
    stall = STALL_EN && !i_reset && i_alu_valid &&
            i_alu2_reg_write && i_alu2_is_load &&
            (i_alu2_rd != '0) &&
            ((i_alu_rs1_used && (i_alu_rs1 == i_alu2_rd)) ||
             (i_alu_rs2_used && (i_alu_rs2 == i_alu2_rd)));
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign o_data1     = od[0];
  assign o_data2     = od[1];
  assign o_src1      = osrc[0];
  assign o_src2      = osrc[1];
  assign o_stall     = stall;
  assign o_stall_cnt = cnt_q;

endmodule
